// File: rtl/ft245_rx_packetizer.sv
// FT245 receive-side packetizer: holds the newest beat so tlast can be attached
// later (max length or idle timeout), then buffers beats in a small FWFT FIFO.
module ft245_rx_packetizer #(
  parameter int bus_width     = 1,
  parameter int fifo_depth    = 16,
  parameter int af_margin     = 4,
  parameter int max_pkt_beats = 512,
  parameter int idle_timeout  = 64
) (
  input  logic                          ft245_dclk,
  input  logic                          rst,
  input  logic [bus_width*8-1:0]        s_axis_tdata,
  input  logic [bus_width-1:0]          s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [bus_width*8-1:0]        m_axis_tdata,
  output logic [bus_width-1:0]          m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          overflow,
  output logic [$clog2(fifo_depth):0]   fifo_count
);
  localparam int DW  = bus_width * 8;
  localparam int AW  = $clog2(fifo_depth);
  localparam int CW  = AW + 1;
  localparam int EW  = DW + bus_width + 1;
  localparam int BCW = $clog2(max_pkt_beats) + 1;
  localparam int IW  = $clog2(idle_timeout) + 1;
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(max_pkt_beats - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(idle_timeout - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(fifo_depth);
  localparam logic [CW-1:0]  AF_CNT    = CW'(fifo_depth - af_margin);

  logic [DW-1:0]        h_data_q, h_data_d;
  logic [bus_width-1:0] h_keep_q, h_keep_d;
  logic                 h_vld_q, h_vld_d;
  logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 overflow_q, overflow_d;
  logic                 s_ready_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        mem_q [fifo_depth];
  logic [EW-1:0]        head;

  logic in_beat, pop, can_push, idle_sat, timeout, push_a, push_b, push, push_last;

  assign in_beat   = s_axis_tvalid & (|s_axis_tkeep);
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign can_push  = (count_q != FULL_CNT) | pop;
  assign idle_sat  = (idle_cnt_q == IDLE_LAST);
  assign timeout   = h_vld_q & ~in_beat & idle_sat;
  assign push_a    = in_beat & h_vld_q & can_push;
  assign push_b    = timeout & can_push;
  assign push      = push_a | push_b;
  // a flush that stalled on a full FIFO still owes its tlast to the held beat
  assign push_last = push_b | flush_pend_q | (beat_cnt_q == BEAT_LAST);

  always_comb begin
    h_data_d     = h_data_q;
    h_keep_d     = h_keep_q;
    h_vld_d      = h_vld_q;
    idle_cnt_d   = idle_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    overflow_d   = overflow_q;
    flush_pend_d = timeout & ~can_push;
    count_d      = count_q;
    if (in_beat) begin
      idle_cnt_d = '0;
      if (!h_vld_q || can_push) begin
        h_data_d = s_axis_tdata;
        h_keep_d = s_axis_tkeep;
        h_vld_d  = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      if (h_vld_q && !idle_sat) idle_cnt_d = idle_cnt_q + 1'b1;
      if (push_b) h_vld_d = 1'b0;
    end
    if (push) beat_cnt_d = push_last ? '0 : beat_cnt_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ft245_dclk or posedge rst) begin
    if (rst) begin
      h_data_q     <= '0;
      h_keep_q     <= '0;
      h_vld_q      <= 1'b0;
      idle_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      s_ready_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      h_data_q     <= h_data_d;
      h_keep_q     <= h_keep_d;
      h_vld_q      <= h_vld_d;
      idle_cnt_q   <= idle_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      overflow_q   <= overflow_d;
      flush_pend_q <= flush_pend_d;
      s_ready_q    <= (count_d < AF_CNT);
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge ft245_dclk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, h_keep_q, h_data_q};
  end

  // outputs read zero whenever the FIFO is empty, including during reset
  assign head          = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[DW-1:0] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? head[DW+bus_width-1:DW] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[EW-1];
  assign s_axis_tready = s_ready_q;
  assign overflow      = overflow_q;
  assign fifo_count    = count_q;
endmodule

// File: tb/tb_ft245_rx_packetizer.sv
// Directed bench for ft245_rx_packetizer: timeout/max-length framing, backpressure,
// empty-beat filtering, full-FIFO flush stall and asynchronous reset.
module tb_ft245_rx_packetizer;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic [0:0] s_keep = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic [0:0] m_keep;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_last;
  logic       ovf;
  logic [4:0] count;

  ft245_rx_packetizer #(
    .bus_width(1), .fifo_depth(16), .af_margin(4), .max_pkt_beats(4), .idle_timeout(T)
  ) dut (
    .ft245_dclk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_last),
    .overflow(ovf), .fifo_count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q_data[$];
  bit         q_last[$];
  int         q_cyc[$];
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_cyc.push_back(cyc);
    end
  end

  int passed = 0, total = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic k, output int acc);
    @(posedge clk); #2;
    s_valid = v; s_data = d; s_keep = k;
    acc = cyc + 1;
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, q_data.size(), n);
  endtask

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; s_valid = 1'b0; s_keep = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clear_q();
  endtask

  initial begin
    int acc, e, j;

    // reset state
    #12;
    chk("rst s_ready", s_ready, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst count", count, 0);
    chk("rst overflow", ovf, 0);
    chk("rst m_data", m_data, 0);
    chk("rst m_last", m_last, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("s_ready after release", s_ready, 1);

    // basic timeout framing
    m_ready = 1'b1;
    drive(1, 8'h11, 1, acc);
    drive(1, 8'h22, 1, acc);
    drive(1, 8'h33, 1, e);
    drive(0, 8'h00, 0, acc);
    wait_q(3, T + 10, "t1 beats");
    chk("t1 d0", q_data[0], 8'h11); chk("t1 l0", q_last[0], 0);
    chk("t1 d1", q_data[1], 8'h22); chk("t1 l1", q_last[1], 0);
    chk("t1 d2", q_data[2], 8'h33); chk("t1 l2", q_last[2], 1);
    chk("t1 latency", q_cyc[2] - e, T);
    chk("t1 overflow", ovf, 0);

    // max-length framing (max_pkt_beats=4)
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) drive(1, 8'(i), 1, e);
    drive(0, 8'h00, 0, acc);
    wait_q(10, T + 20, "t2 beats");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2 d%0d", i), q_data[i], i);
      chk($sformatf("t2 l%0d", i), q_last[i], (i == 3 || i == 7 || i == 9));
    end
    chk("t2 latency", q_cyc[9] - e, T);

    // backpressure and overflow
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'(i), 1, acc);
      if (i > 0) begin
        @(negedge clk);
        j = (i - 1 > 16) ? 16 : i - 1;
        chk($sformatf("t3 count b%0d", i - 1), count, j);
        chk($sformatf("t3 s_ready b%0d", i - 1), s_ready, (j < 12));
        chk($sformatf("t3 ovf b%0d", i - 1), ovf, (i - 1 >= 17));
      end
    end
    drive(0, 8'h00, 0, acc);
    @(negedge clk);
    chk("t3 count full", count, 16);
    chk("t3 overflow", ovf, 1);
    chk("t3 s_ready", s_ready, 0);
    chk("t3 head", m_data, 8'h00);
    @(posedge clk); #2 m_ready = 1'b1;
    wait_q(17, T + 40, "t3 beats");
    repeat (T + 5) @(negedge clk);
    chk("t3 no extra", q_data.size(), 17);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t3 d%0d", i), q_data[i], i);
      chk($sformatf("t3 l%0d", i), q_last[i], (i % 4 == 3 || i == 16));
    end

    // empty-beat filtering
    do_reset();
    m_ready = 1'b1;
    drive(1, 8'hAA, 1, e);
    repeat (5) drive(1, 8'h5C, 0, acc);
    drive(0, 8'h00, 0, acc);
    wait_q(1, T + 10, "t4 beat");
    repeat (5) @(negedge clk);
    chk("t4 single", q_data.size(), 1);
    chk("t4 data", q_data[0], 8'hAA);
    chk("t4 last", q_last[0], 1);
    chk("t4 latency", q_cyc[0] - e, T);

    // full-FIFO flush stall
    do_reset();
    for (int i = 0; i < 17; i++) drive(1, 8'(i), 1, acc);
    drive(0, 8'h00, 0, acc);
    repeat (T + 5) @(negedge clk);
    chk("t5 stalled count", count, 16);
    chk("t5 stalled valid", m_valid, 1);
    @(posedge clk); #2 m_ready = 1'b1;
    @(posedge clk); #2 m_ready = 1'b0;
    @(negedge clk);
    chk("t5 count after pop+flush", count, 16);
    chk("t5 one pop", q_data.size(), 1);
    chk("t5 head after pop", m_data, 8'h01);
    @(posedge clk); #2 m_ready = 1'b1;
    wait_q(17, 40, "t5 beats");
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t5 d%0d", i), q_data[i], i);
      chk($sformatf("t5 l%0d", i), q_last[i], (i % 4 == 3 || i == 16));
    end

    // reset mid-packet
    do_reset();
    for (int i = 0; i < 20; i++) drive(1, 8'(i), 1, acc);
    drive(0, 8'h00, 0, acc);
    @(negedge clk);
    chk("t6 pre count", count, 16);
    chk("t6 pre overflow", ovf, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6 async m_valid", m_valid, 0);
    chk("t6 async count", count, 0);
    chk("t6 async overflow", ovf, 0);
    @(posedge clk); #2 rst = 1'b0;
    clear_q();
    m_ready = 1'b1;
    drive(1, 8'h55, 1, e);
    drive(0, 8'h00, 0, acc);
    wait_q(1, T + 10, "t6 beat");
    repeat (3) @(negedge clk);
    chk("t6 single", q_data.size(), 1);
    chk("t6 data", q_data[0], 8'h55);
    chk("t6 last", q_last[0], 1);
    chk("t6 latency", q_cyc[0] - e, T);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
